min_prefetch_unit: RTL
======================

# min_prefetch_unit

Instruction prefetch stage for the MIN execution unit. It fetches 16-bit instruction words sequentially from program memory into a small FIFO queue and presents them, with their addresses, to the execution unit's instruction-register load path. The execution unit consumes words through a valid/ready handshake and redirects fetch on taken branches or PC writes. A redirect flushes the queue and restarts fetch at the new address.

## Interface
- DEPTH, 4, queue entries; power of 2, ≥2
- RESET_PC, 16'h0000, fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  16  new fetch address
- mem_req  out  1  memory read request, registered
- mem_addr  out  16  read address, registered, stable while mem_req=1
- mem_ack  in  1  read completes this cycle; mem_rdata valid
- mem_rdata  in  16  read data
- instr_valid  out  1  queue head valid
- instr_data  out  16  queue head instruction word
- instr_pc  out  16  address the head word was fetched from
- instr_ready  in  1  execution unit accepts head this cycle
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Queue entries hold {pc, data}. Pointers wrap modulo DEPTH. fetch_pc increments modulo 2^16, so 16'hFFFF is followed by 16'h0000.
- FSM states:
  - IDLE: if no redirect and count<DEPTH, set mem_req=1 and mem_addr=fetch_pc, then go to REQ. Otherwise stay.
  - REQ: mem_req=1. On mem_ack without redirect: push {mem_addr, mem_rdata}, fetch_pc+=1, mem_req=0, go to IDLE. Without mem_ack, hold mem_req and mem_addr unchanged.
  - DISCARD: a request is in flight but stale. Hold mem_req and mem_addr. On mem_ack, drop the data, mem_req=0, go to IDLE.
- Only one request is outstanding at a time. Issuing requires count<DEPTH, and count cannot grow while the request is outstanding, so the push on mem_ack never overflows.
- Pop: when instr_valid && instr_ready, advance the head and decrement count. A pop and a push in the same cycle leave count unchanged.
- instr_valid = (count!=0) && !redirect_valid.
- Redirect (redirect_valid=1) has priority over everything else:
  - count←0, pointers←0, fetch_pc←redirect_pc.
  - instr_ready in that cycle is ignored.
  - In IDLE: stay in IDLE; fetch from redirect_pc starts the next cycle.
  - In REQ with mem_ack the same cycle: drop the data, go to IDLE.
  - In REQ without mem_ack: go to DISCARD. The request is never retracted.
  - In DISCARD: update fetch_pc again and stay; if mem_ack arrives, drop the data and go to IDLE.
- Reset (including mid-request):
  - state=IDLE, mem_req=0, mem_addr=0, count=0, fetch_pc=RESET_PC, all queue entries cleared to 0.
  - Outputs after reset: instr_valid=0, instr_data=0, instr_pc=0.
  - Any mem_ack arriving after reset is ignored.

## Timing
- mem_req rises on the clock edge after the IDLE cycle in which the issue condition holds. mem_ack is accepted in any cycle where mem_req=1, including the first.
- With zero-wait memory, fetch throughput is 1 word per 2 cycles.
- First word after reset with zero-wait memory:
  - mem_req=1 in cycle 1 after reset deasserts.
  - instr_valid=1 in cycle 2.
- Redirect-to-first-valid latency (zero-wait, state IDLE or REQ+ack at redirect): 3 cycles.
  - Cycle 0: redirect.
  - Cycle 1: IDLE issues the request.
  - Cycle 2: REQ, mem_ack.
  - Cycle 3: instr_valid=1.
- A pushed word is visible at the head on the cycle after its mem_ack. There is no combinational path from mem_rdata to instr_data.
- Full queue (count=DEPTH) with no pop: stay in IDLE, mem_req=0. After a pop, the issue is evaluated on the next cycle.

## Test plan
- Reset with RESET_PC=16'h0010; memory returns data=addr^16'hA5A5 with zero wait and instr_ready=1 → instr_pc sequence 0x0010, 0x0011, 0x0012…; instr_data 0xA5B5, 0xA5B4, …; one word every 2 cycles.
- instr_ready=0 → count saturates at 4, mem_req stays 0; a single pop → exactly one new request with mem_addr=0x0014.
- Memory with 3 wait states, redirect to 0x0100 in the second wait cycle → mem_req/mem_addr held until mem_ack, then the data is dropped; the next request has mem_addr=0x0100; instr_valid=0 throughout until the 0x0100 word is pushed.
- redirect_valid in the same cycle as mem_ack and instr_ready with count=2 → count=0, nothing pushed or popped, next mem_addr=redirect_pc.
- fetch_pc=16'hFFFE, zero wait → instr_pc sequence 0xFFFE, 0xFFFF, 0x0000.
- Assert reset while in REQ, then deassert with a late mem_ack arriving → count=0, instr_valid=0, first request at RESET_PC, and the late ack data is not pushed.

Source files
------------

// File: rtl/min_prefetch_unit.sv
// min_prefetch_unit: sequential instruction prefetch into a small {pc, data} queue.
// Only one memory read is ever outstanding. A redirect flushes the queue and
// restarts fetch at the new address. A request already in flight when the
// redirect arrives is completed and its data dropped, because requests are
// never retracted.
module min_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      redirect_valid,
    input  logic [15:0]               redirect_pc,
    output logic                      mem_req,
    output logic [15:0]               mem_addr,
    input  logic                      mem_ack,
    input  logic [15:0]               mem_rdata,
    output logic                      instr_valid,
    output logic [15:0]               instr_data,
    output logic [15:0]               instr_pc,
    input  logic                      instr_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic             mem_req_n;
    logic [15:0]      mem_addr_n;
    logic [15:0]      fetch_pc;
    logic [15:0]      fetch_pc_n;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [15:0]      q_pc   [DEPTH];
    logic [15:0]      q_data [DEPTH];

    // Head of queue is presented straight from storage; a redirect hides it.
    assign instr_valid = (count != '0) && !redirect_valid;
    assign instr_data  = q_data[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];
    assign pop         = instr_valid && instr_ready;

    // Fetch FSM next-state and request/fetch-address decisions.
    always_comb begin
        state_n    = state;
        mem_req_n  = mem_req;
        mem_addr_n = mem_addr;
        fetch_pc_n = fetch_pc;
        push       = 1'b0;

        if (redirect_valid) begin
            fetch_pc_n = redirect_pc;
        end

        case (state)
            ST_IDLE: begin
                if (!redirect_valid && (count < CNT_W'(DEPTH))) begin
                    mem_req_n  = 1'b1;
                    mem_addr_n = fetch_pc;
                    state_n    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    mem_req_n = 1'b0;
                    state_n   = ST_IDLE;
                    if (!redirect_valid) begin
                        push       = 1'b1;
                        fetch_pc_n = fetch_pc + 16'd1;
                    end
                end else if (redirect_valid) begin
                    state_n = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (mem_ack) begin
                    mem_req_n = 1'b0;
                    state_n   = ST_IDLE;
                end
            end
            default: begin
                mem_req_n = 1'b0;
                state_n   = ST_IDLE;
            end
        endcase
    end

    // FSM state, memory request and fetch address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= 16'h0000;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_n;
            mem_req  <= mem_req_n;
            mem_addr <= mem_addr_n;
            fetch_pc <= fetch_pc_n;
        end
    end

    // Queue storage, pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]   <= 16'h0000;
                q_data[i] <= 16'h0000;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]   <= mem_addr;
                q_data[wr_ptr] <= mem_rdata;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
